// File: rtl/bram_stream_reader_if.sv
// ============================================================================
// Module      : bram_stream_reader_if
// Description : Valid/ready stream carrying data words with a last flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bram_stream_reader_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] m_tdata;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  m_tlast;

    modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
    modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

`default_nettype wire

// File: rtl/bram_stream_reader.sv
// ============================================================================
// Module      : bram_stream_reader
// Description : Burst reader for a 1-cycle-latency BRAM, streaming words out
//               through a 2-entry buffer that absorbs the read latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_stream_reader #(
    parameter int N_ADDR     = 256,
    parameter int DATA_WIDTH = 16,
    localparam int AW        = $clog2(N_ADDR)
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  start,
    input  wire logic [AW-1:0]         base,
    input  wire logic [AW:0]           len,
    output logic                       ren,
    output logic [AW-1:0]              radd,
    input  wire logic [DATA_WIDTH-1:0] rdata,
    bram_stream_reader_if.master       m_axis,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [AW:0] c_REM_ONE = (AW+1)'(1);

    state_t                r_state;
    state_t                w_state_next;
    logic [AW-1:0]         r_addr;
    logic [AW:0]           r_remaining;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic [DATA_WIDTH-1:0] r_head_data;
    logic [DATA_WIDTH-1:0] r_tail_data;
    logic                  r_head_last;
    logic                  r_tail_last;
    logic [1:0]            r_occ;
    logic                  r_done;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_room;
    logic                  w_ren;
    logic                  w_load;
    logic                  w_done_next;

    assign w_pop  = (r_occ != 2'd0) && m_axis.m_tready;
    assign w_push = r_inflight;
    // occupancy + inflight - pop < 2, rearranged to stay unsigned
    assign w_room = ({1'b0, r_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});

    always_comb begin
        w_state_next = r_state;
        w_ren        = 1'b0;
        w_load       = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        w_state_next = S_READ;
                        w_load       = 1'b1;
                    end else begin
                        w_done_next  = 1'b1;
                    end
                end
            end
            S_READ: begin
                if ((r_remaining != '0) && w_room) begin
                    w_ren = 1'b1;
                end
                if (w_ren && (r_remaining == c_REM_ONE)) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && r_head_last) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_done          <= 1'b0;
            r_addr          <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_done          <= w_done_next;
            if (w_load) begin
                r_addr      <= base;
                r_remaining <= len;
            end else if (w_ren) begin
                r_addr      <= r_addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end
            r_inflight      <= w_ren;
            r_inflight_last <= w_ren && (r_remaining == c_REM_ONE);
        end
    end

    // Head entry doubles as the output register; tail holds the overflow word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_data <= '0;
            r_head_last <= 1'b0;
            r_tail_data <= '0;
            r_tail_last <= 1'b0;
            r_occ       <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_head_data <= rdata;
                        r_head_last <= r_inflight_last;
                    end else begin
                        r_tail_data <= rdata;
                        r_tail_last <= r_inflight_last;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    if (r_occ == 2'd2) begin
                        r_head_data <= r_tail_data;
                        r_head_last <= r_tail_last;
                    end else begin
                        r_head_last <= 1'b0;
                    end
                    r_occ <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_head_data <= rdata;
                        r_head_last <= r_inflight_last;
                    end else begin
                        r_head_data <= r_tail_data;
                        r_head_last <= r_tail_last;
                        r_tail_data <= rdata;
                        r_tail_last <= r_inflight_last;
                    end
                end
                default: begin
                    r_occ <= r_occ;
                end
            endcase
        end
    end

    assign ren             = w_ren;
    assign radd            = w_ren ? r_addr : '0;
    assign m_axis.m_tdata  = r_head_data;
    assign m_axis.m_tvalid = (r_occ != 2'd0);
    assign m_axis.m_tlast  = r_head_last;
    assign busy            = (r_state != S_IDLE);
    assign done            = r_done;

endmodule

`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
// ============================================================================
// Module      : tb_bram_stream_reader
// Description : Scoreboard bench for bram_stream_reader with a BRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bram_stream_reader;

    localparam int N_ADDR = 256;
    localparam int DW     = 16;
    localparam int AW     = 8;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base  = '0;
    logic [AW:0]   len   = '0;
    logic          ren;
    logic [AW-1:0] radd;
    logic [DW-1:0] rdata = '0;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [N_ADDR];
    beat_t         exp_q[$];
    logic [AW-1:0] addr_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int beats_seen  = 0;
    int issued      = 0;
    int popped      = 0;
    int rdy_mode    = 0;

    bram_stream_reader_if #(.DATA_WIDTH(DW)) s_if ();

    bram_stream_reader #(.N_ADDR(N_ADDR), .DATA_WIDTH(DW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .base   (base),
        .len    (len),
        .ren    (ren),
        .radd   (radd),
        .rdata  (rdata),
        .m_axis (s_if.master),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ren) rdata <= mem[radd];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Ready pattern: 0 = always ready, 1 = random, 2 = fully stalled
    initial begin
        s_if.m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       s_if.m_tready = 1'b1;
                1:       s_if.m_tready = 1'($urandom_range(0, 1));
                default: s_if.m_tready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every transfer and every read issue
    initial begin
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic          pop;
        int            pending;
        beat_t         e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                issued     = 0;
                popped     = 0;
            end else begin
                pop = s_if.m_tvalid && s_if.m_tready;
                if (prev_stall) begin
                    check("stall_valid", s_if.m_tvalid, 1);
                    check("stall_data", s_if.m_tdata, prev_data);
                end
                if (ren) begin
                    pending = issued - popped;
                    check("ren_room", (pending - (pop ? 1 : 0)) < 2, 1);
                    check("ren_expected", addr_q.size() > 0, 1);
                    if (addr_q.size() > 0) check("radd", radd, addr_q.pop_front());
                    issued++;
                end
                if (pop) begin
                    check("beat_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("tdata", s_if.m_tdata, e.d);
                        check("tlast", s_if.m_tlast, e.l);
                    end
                    beats_seen++;
                    popped++;
                end
                prev_stall = s_if.m_tvalid && !s_if.m_tready;
                prev_data  = s_if.m_tdata;
            end
        end
    end

    task automatic push_burst(input logic [AW-1:0] b, input int l);
        logic [AW-1:0] a;
        beat_t         e;
        a = b;
        for (int i = 0; i < l; i++) begin
            addr_q.push_back(a);
            e.d = mem[a];
            e.l = (i == l - 1);
            exp_q.push_back(e);
            a = a + 1'b1;
        end
    endtask

    // Returns at #1 after the edge that accepted start
    task automatic pulse_start(input logic [AW-1:0] b, input int l);
        @(posedge clk);
        #1;
        start = 1'b1;
        base  = b;
        len   = (AW+1)'(l);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (!done && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_seen", done, 1);
        check("busy_at_done", busy, 0);
    endtask

    initial begin
        int n;
        int bs;
        for (int i = 0; i < N_ADDR; i++) mem[i] = DW'(16'h100 + i);

        #1;
        check("rst_ren", ren, 0);
        check("rst_tvalid", s_if.m_tvalid, 0);
        check("rst_tdata", s_if.m_tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Test 1: base 4, len 8, latency and full throughput
        push_burst(8'd4, 8);
        pulse_start(8'd4, 8);
        check("t1_ren_lat", ren, 1);
        check("t1_radd0", radd, 4);
        check("t1_busy", busy, 1);
        check("t1_tvalid_c1", s_if.m_tvalid, 0);
        @(posedge clk); #1;
        check("t1_tvalid_c2", s_if.m_tvalid, 0);
        @(posedge clk); #1;
        check("t1_tvalid_c3", s_if.m_tvalid, 1);
        check("t1_first_data", s_if.m_tdata, 16'h104);
        wait_done(2, n);
        check("t1_done_cycle", n, 10);
        check("t1_drained", exp_q.size(), 0);
        @(posedge clk); #1;
        check("t1_done_pulse", done, 0);

        // Test 2: address wrap
        push_burst(8'd254, 4);
        pulse_start(8'd254, 4);
        wait_done(0, n);
        check("t2_done_cycle", n, 6);
        check("t2_drained", exp_q.size() + addr_q.size(), 0);

        // Test 3: random backpressure, then a fully stalled burst
        rdy_mode = 1;
        push_burst(8'd0, 6);
        pulse_start(8'd0, 6);
        wait_done(0, n);
        check("t3_drained", exp_q.size(), 0);
        rdy_mode = 2;
        push_burst(8'd10, 5);
        pulse_start(8'd10, 5);
        repeat (12) @(posedge clk);
        #1;
        check("t3_stall_valid", s_if.m_tvalid, 1);
        check("t3_stall_busy", busy, 1);
        check("t3_stall_nobeats", exp_q.size(), 5);
        check("t3_stall_pending", issued - popped, 2);
        rdy_mode = 0;
        wait_done(0, n);
        check("t3_stall_drained", exp_q.size(), 0);

        // Test 4: len 0, then start while busy
        pulse_start(8'd7, 0);
        check("t4_len0_done", done, 1);
        check("t4_len0_busy", busy, 0);
        check("t4_len0_ren", ren, 0);
        @(posedge clk); #1;
        check("t4_len0_pulse", done, 0);
        bs = beats_seen;
        push_burst(8'd20, 8);
        pulse_start(8'd20, 8);
        @(posedge clk); #1;
        start = 1'b1;
        base  = 8'd200;
        len   = 9'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(2, n);
        check("t4_beats", beats_seen - bs, 8);
        check("t4_drained", exp_q.size() + addr_q.size(), 0);

        // Test 5: reset during the 3rd beat of a len 16 burst
        bs = beats_seen;
        push_burst(8'd0, 16);
        pulse_start(8'd0, 16);
        n = 0;
        while ((beats_seen - bs) < 2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_third_beat", s_if.m_tvalid, 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_ren", ren, 0);
        check("t5_rst_radd", radd, 0);
        check("t5_rst_tvalid", s_if.m_tvalid, 0);
        check("t5_rst_tdata", s_if.m_tdata, 0);
        check("t5_rst_tlast", s_if.m_tlast, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        exp_q.delete();
        addr_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("t5_no_done", done, 0);
        end
        push_burst(8'd0, 2);
        pulse_start(8'd0, 2);
        wait_done(0, n);
        check("t5_done_cycle", n, 4);
        check("t5_drained", exp_q.size(), 0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
